// File: rtl/hwloop_regs_pkg.sv
// Shared constants and types for the hardware-loop register file.
// Optional macro HWLP_ALIGN_EN (see hwloop_slot) forces stored addresses halfword-aligned.
package hwloop_pkg;
   localparam int DATA_W     = 32;
   localparam int N_REGS     = 2;
   localparam int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1;

   localparam int WE_START = 0;
   localparam int WE_END   = 1;
   localparam int WE_CNT   = 2;

   typedef logic [DATA_W-1:0] hwlp_addr_t;
endpackage

// File: rtl/hwloop_regs_if.sv
// Bus between the ID stage / loop controller (master) and the loop register file (slave).
// Inputs are sampled on the rising clock edge; outputs come straight from registers.
interface hwloop_regs_if
   import hwloop_pkg::*;
();
   hwlp_addr_t                    hwlp_start_data_i;
   hwlp_addr_t                    hwlp_end_data_i;
   hwlp_addr_t                    hwlp_cnt_data_i;
   logic [2:0]                    hwlp_we_i;
   logic [N_REG_BITS-1:0]         hwlp_regid_i;
   logic                          valid_i;
   logic [N_REGS-1:0]             hwlp_dec_cnt_i;
   logic [N_REGS*DATA_W-1:0]      hwlp_start_addr_o;
   logic [N_REGS*DATA_W-1:0]      hwlp_end_addr_o;
   logic [N_REGS*DATA_W-1:0]      hwlp_counter_o;

   modport master (
      output hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
             hwlp_regid_i, valid_i, hwlp_dec_cnt_i,
      input  hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o
   );

   modport slave (
      input  hwlp_start_data_i, hwlp_end_data_i, hwlp_cnt_data_i, hwlp_we_i,
             hwlp_regid_i, valid_i, hwlp_dec_cnt_i,
      output hwlp_start_addr_o, hwlp_end_addr_o, hwlp_counter_o
   );
endinterface

// File: rtl/hwloop_regs_slot.sv
// One hardware loop's start/end/count registers. With HWLP_ALIGN_EN defined,
// start/end writes clear bit 0; counter writes are always stored verbatim.
module hwloop_slot
   import hwloop_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       sel,
   input  logic [2:0] we,
   input  hwlp_addr_t start_data,
   input  hwlp_addr_t end_data,
   input  hwlp_addr_t cnt_data,
   input  logic       dec,
   input  logic       valid,
   output hwlp_addr_t start_q,
   output hwlp_addr_t end_q,
   output hwlp_addr_t cnt_q
);
`ifdef HWLP_ALIGN_EN
   localparam hwlp_addr_t ADDR_MASK = ~hwlp_addr_t'(1);
`else
   localparam hwlp_addr_t ADDR_MASK = '1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         start_q <= '0;
         end_q   <= '0;
         cnt_q   <= '0;
      end else begin
         if (sel && we[WE_START]) start_q <= start_data & ADDR_MASK;
         if (sel && we[WE_END])   end_q   <= end_data & ADDR_MASK;
         // A counter write on this loop wins over a same-cycle decrement.
         if (sel && we[WE_CNT])  cnt_q <= cnt_data;
         else if (dec && valid)  cnt_q <= cnt_q - hwlp_addr_t'(1);
      end
   end
endmodule

// File: rtl/hwloop_regs.sv
// Hardware-loop register file: N_REGS slots with packed start/end/counter outputs.
// Build option HWLP_ALIGN_EN halfword-aligns stored start/end addresses.
module hwloop_regs
   import hwloop_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   hwloop_regs_if.slave  bus
);
   for (genvar i = 0; i < N_REGS; i++) begin : g_slot
      logic       sel;
      hwlp_addr_t start_q;
      hwlp_addr_t end_q;
      hwlp_addr_t cnt_q;

      // An out-of-range index matches no slot, so such writes are dropped.
      assign sel = (bus.hwlp_regid_i == N_REG_BITS'(i));

      hwloop_slot u_slot (
         .clk        (clk),
         .rst        (rst),
         .sel        (sel),
         .we         (bus.hwlp_we_i),
         .start_data (bus.hwlp_start_data_i),
         .end_data   (bus.hwlp_end_data_i),
         .cnt_data   (bus.hwlp_cnt_data_i),
         .dec        (bus.hwlp_dec_cnt_i[i]),
         .valid      (bus.valid_i),
         .start_q    (start_q),
         .end_q      (end_q),
         .cnt_q      (cnt_q)
      );

      assign bus.hwlp_start_addr_o[i*DATA_W +: DATA_W] = start_q;
      assign bus.hwlp_end_addr_o[i*DATA_W +: DATA_W]   = end_q;
      assign bus.hwlp_counter_o[i*DATA_W +: DATA_W]    = cnt_q;
   end
endmodule

// File: tb/tb_hwloop_regs.sv
// Directed + random bench for hwloop_regs: reference model feeds an expected-state
// queue, plus constant field checks for the directed scenarios.
module tb_hwloop_regs;
  import hwloop_pkg::*;

  localparam int SW = 3 * N_REGS * DATA_W;
`ifdef HWLP_ALIGN_EN
  localparam logic [31:0] EXP_ALIGN = 32'h0000_0202;
`else
  localparam logic [31:0] EXP_ALIGN = 32'h0000_0203;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hwloop_regs_if bus ();
  hwloop_regs dut (.clk(clk), .rst(rst), .bus(bus));

  logic [SW-1:0] exp_q[$];
  string         tag_q[$];
  logic [31:0]   m_start[N_REGS];
  logic [31:0]   m_end[N_REGS];
  logic [31:0]   m_cnt[N_REGS];
  int            vectors = 0;
  int            miscompares = 0;

  function automatic logic [31:0] fld(input logic [N_REGS*DATA_W-1:0] v, input int i);
    return v[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [SW-1:0] model_state();
    logic [SW-1:0] s;
    s = '0;
    for (int i = 0; i < N_REGS; i++) begin
      s[(2*N_REGS+i)*DATA_W +: DATA_W] = m_start[i];
      s[(N_REGS+i)*DATA_W +: DATA_W]   = m_end[i];
      s[i*DATA_W +: DATA_W]            = m_cnt[i];
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare the full register state.
  task automatic apply(input string tag, input logic r, input logic [2:0] we,
                       input logic [N_REG_BITS-1:0] id, input logic [31:0] s,
                       input logic [31:0] e, input logic [31:0] c,
                       input logic v, input logic [N_REGS-1:0] d);
    logic [SW-1:0] exp_s;
    logic [SW-1:0] obs_s;
    string         t;
    rst = r;
    bus.hwlp_we_i = we;
    bus.hwlp_regid_i = id;
    bus.hwlp_start_data_i = s;
    bus.hwlp_end_data_i = e;
    bus.hwlp_cnt_data_i = c;
    bus.valid_i = v;
    bus.hwlp_dec_cnt_i = d;
    for (int i = 0; i < N_REGS; i++) begin
      if (r) begin
        m_start[i] = '0;
        m_end[i] = '0;
        m_cnt[i] = '0;
      end else begin
        if (we[WE_START] && int'(id) == i) begin
`ifdef HWLP_ALIGN_EN
          m_start[i] = {s[31:1], 1'b0};
`else
          m_start[i] = s;
`endif
        end
        if (we[WE_END] && int'(id) == i) begin
`ifdef HWLP_ALIGN_EN
          m_end[i] = {e[31:1], 1'b0};
`else
          m_end[i] = e;
`endif
        end
        if (we[WE_CNT] && int'(id) == i) m_cnt[i] = c;
        else if (d[i] && v) m_cnt[i] = m_cnt[i] - 32'd1;
      end
    end
    exp_q.push_back(model_state());
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp_s = exp_q.pop_front();
    t = tag_q.pop_front();
    obs_s = {bus.hwlp_start_addr_o, bus.hwlp_end_addr_o, bus.hwlp_counter_o};
    vectors++;
    assert (obs_s === exp_s) else begin
      miscompares++;
      $error("FAIL state_%s observed=%h expected=%h", t, obs_s, exp_s);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.hwlp_we_i = '0;
    bus.hwlp_regid_i = '0;
    bus.hwlp_start_data_i = '0;
    bus.hwlp_end_data_i = '0;
    bus.hwlp_cnt_data_i = '0;
    bus.valid_i = 1'b0;
    bus.hwlp_dec_cnt_i = '0;
    #2;

    // Reset with garbage on every input.
    for (int k = 0; k < 2; k++)
      apply("reset", 1'b1, 3'($urandom_range(0, 7)), N_REG_BITS'($urandom_range(0, 1)),
            $urandom, $urandom, $urandom, 1'b1, N_REGS'($urandom_range(0, 3)));
    chk("reset_start", bus.hwlp_start_addr_o[31:0] | bus.hwlp_start_addr_o[63:32], 32'h0);
    chk("reset_end", bus.hwlp_end_addr_o[31:0] | bus.hwlp_end_addr_o[63:32], 32'h0);
    chk("reset_cnt", bus.hwlp_counter_o[31:0] | bus.hwlp_counter_o[63:32], 32'h0);

    apply("write_all", 1'b0, 3'b111, 1'b1, 32'h100, 32'h120, 32'd5, 1'b0, 2'b00);
    chk("w_start1", fld(bus.hwlp_start_addr_o, 1), 32'h100);
    chk("w_end1", fld(bus.hwlp_end_addr_o, 1), 32'h120);
    chk("w_cnt1", fld(bus.hwlp_counter_o, 1), 32'd5);
    chk("w_start0", fld(bus.hwlp_start_addr_o, 0), 32'h0);
    chk("w_cnt0", fld(bus.hwlp_counter_o, 0), 32'h0);

    apply("cnt0_3", 1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd3, 1'b0, 2'b00);
    apply("dec_a", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01);
    chk("dec_2", fld(bus.hwlp_counter_o, 0), 32'd2);
    apply("dec_b", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01);
    chk("dec_1", fld(bus.hwlp_counter_o, 0), 32'd1);
    apply("dec_c", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01);
    chk("dec_0", fld(bus.hwlp_counter_o, 0), 32'd0);
    apply("dec_noval", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b01);
    chk("dec_hold", fld(bus.hwlp_counter_o, 0), 32'd0);
    apply("dec_wrap", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b01);
    chk("dec_wrap", fld(bus.hwlp_counter_o, 0), 32'hFFFF_FFFF);

    apply("cnt1_7", 1'b0, 3'b100, 1'b1, 32'h0, 32'h0, 32'd7, 1'b0, 2'b00);
    apply("collide", 1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd10, 1'b1, 2'b11);
    chk("col_cnt0", fld(bus.hwlp_counter_o, 0), 32'd10);
    chk("col_cnt1", fld(bus.hwlp_counter_o, 1), 32'd6);

    apply("cnt0_4", 1'b0, 3'b100, 1'b0, 32'h0, 32'h0, 32'd4, 1'b0, 2'b00);
    apply("cnt1_9", 1'b0, 3'b100, 1'b1, 32'h0, 32'h0, 32'd9, 1'b0, 2'b00);
    apply("dec_both", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b11);
    chk("both_cnt0", fld(bus.hwlp_counter_o, 0), 32'd3);
    chk("both_cnt1", fld(bus.hwlp_counter_o, 1), 32'd8);

    apply("align", 1'b0, 3'b101, 1'b0, 32'h203, 32'h0, 32'h3, 1'b0, 2'b00);
    chk("align_start0", fld(bus.hwlp_start_addr_o, 0), EXP_ALIGN);
    chk("align_cnt0", fld(bus.hwlp_counter_o, 0), 32'h3);
    apply("end_wr", 1'b0, 3'b010, 1'b1, 32'h0, 32'h203, 32'h0, 1'b0, 2'b00);
    chk("end1", fld(bus.hwlp_end_addr_o, 1), EXP_ALIGN);
    chk("end1_start", fld(bus.hwlp_start_addr_o, 1), 32'h100);

    for (int k = 0; k < 24; k++)
      apply("random", 1'b0, 3'($urandom_range(0, 7)), N_REG_BITS'($urandom_range(0, 1)),
            $urandom, $urandom, 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            N_REGS'($urandom_range(0, 3)));

    apply("midreset", 1'b1, 3'b111, 1'b0, 32'h55, 32'h66, 32'h77, 1'b1, 2'b11);
    chk("mid_cnt0", fld(bus.hwlp_counter_o, 0), 32'h0);
    chk("mid_start0", fld(bus.hwlp_start_addr_o, 0), 32'h0);
    apply("post_reset", 1'b0, 3'b000, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hwloop_regs.md
Name: hwloop_regs

Overview:
- Register file holding the hardware-loop state (start address, end address, iteration counter) for the core's zero-overhead loop unit.
- Sits between the ID stage and the hwloop controller.
  - Written by lp.setup/lp.starti/lp.endi/lp.count instructions and by CSR writes.
  - The controller decrements each loop counter when its loop wraps.

Parameters:
- N_REGS, 2, number of hardware loops.
- N_REG_BITS, $clog2(N_REGS) (1 for the default), width of the loop index.
- DATA_W, 32, address/counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hwlp_start_data_i  in  DATA_W  start address to write.
- hwlp_end_data_i  in  DATA_W  end address to write.
- hwlp_cnt_data_i  in  DATA_W  counter value to write.
- hwlp_we_i  in  3  write enables: bit0 start, bit1 end, bit2 counter.
- hwlp_regid_i  in  N_REG_BITS  loop index targeted by writes.
- valid_i  in  1  pipeline-valid qualifier for decrements.
- hwlp_dec_cnt_i  in  N_REGS  per-loop decrement request.
- hwlp_start_addr_o  out  N_REGS*DATA_W  start addresses; loop i occupies bits [i*DATA_W +: DATA_W].
- hwlp_end_addr_o  out  N_REGS*DATA_W  end addresses; same packing.
- hwlp_counter_o  out  N_REGS*DATA_W  counters; same packing.

Interface note: one clock; reset is synchronous and active-high.

Behaviour:
- Storage per loop i: start_q[i], end_q[i], cnt_q[i]. All registered.
- Outputs are driven directly from the registers. No combinational path from any input to any output.
- Reset:
  - rst=1 at a rising edge clears every start_q, end_q and cnt_q to 0.
  - Reset overrides all writes and decrements in the same cycle.
  - Reset asserted mid-operation clears state on that edge regardless of pending requests.
- Start write: hwlp_we_i[0]=1 sets start_q[hwlp_regid_i] <= hwlp_start_data_i. Other loops are unchanged.
- End write: hwlp_we_i[1]=1 sets end_q[hwlp_regid_i] <= hwlp_end_data_i.
- Counter update, per loop i, in priority order:
  1. hwlp_we_i[2]=1 and hwlp_regid_i==i: cnt_q[i] <= hwlp_cnt_data_i. A write beats a decrement on the same loop.
  2. Else, hwlp_dec_cnt_i[i]=1 and valid_i=1: cnt_q[i] <= cnt_q[i]-1, modulo 2^DATA_W. A decrement from 0 wraps to 0xFFFFFFFF.
  3. Else: hold.
- hwlp_dec_cnt_i with valid_i=0 has no effect.
- Multiple we bits may be set together; all selected fields of the addressed loop update on the same edge.
- Decrements of different loops may occur simultaneously. A write to loop j does not block a decrement of loop i≠j.
- hwlp_regid_i ≥ N_REGS (possible only for non-power-of-2 N_REGS): the write is ignored.
- Latency: a written or decremented value is visible on the outputs one cycle after the edge.

Optional Feature:
- Macro HWLP_ALIGN_EN.
- Defined:
  - Start and end writes store the data with bit[0] forced to 0, keeping addresses halfword-aligned.
  - Counter writes are unaffected.
- Undefined: all DATA_W bits are stored verbatim.

Decomposition:
- Package hwloop_pkg:
  - DATA_W and N_REGS defaults.
  - Write-enable bit indices WE_START=0, WE_END=1, WE_CNT=2.
  - typedef hwlp_addr_t (logic [DATA_W-1:0]).
- Sub-module hwloop_slot: one loop's start/end/count registers with local write/decrement logic.
  - Takes per-slot select, shared data and we bits, and its own dec bit plus valid_i.
  - The top level generates N_REGS instances and packs the outputs.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with random inputs → all three outputs read 0 (all bits zero).
2. Writes: regid=1, we=3'b111, start=0x100, end=0x120, cnt=5 → loop1 fields read 0x100/0x120/5; loop0 fields remain 0.
3. Decrement: loop0 cnt=3; dec_cnt=2'b01 with valid_i=1 for 3 cycles → counter reads 2, 1, 0. With valid_i=0 it holds at 0. One more valid decrement → 0xFFFFFFFF.
4. Collisions:
   - Same loop: we[2]=1, regid=0, cnt_data=10, with dec_cnt[0]=1 and valid_i=1 → cnt0=10.
   - Other loop, same cycle: dec_cnt[1]=1 with cnt1=7 → cnt1=6.
5. Simultaneous decrements: dec_cnt=2'b11, valid_i=1, counters 4 and 9 → 3 and 8 after one edge.
6. HWLP_ALIGN_EN:
   - Defined: start write 0x203 → 0x202.
   - Undefined: start write 0x203 → 0x203.
   - Either build: cnt write 0x3 → 0x3.
